// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction fetch controller with MMU/imem sequencing and fetch queue
//
// Sequences one fetch at a time: optional SV32 translation through the MMU
// handshake, then an instruction-memory read, then a push into a QDEPTH-entry
// queue. Each queue entry carries its pc, instruction word and trap bits.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   redirect_valid_i/pc_i        flush the queue and restart fetch at a new pc
//   mmu_enable_i                 1: translate through MMU, 0: paddr = vaddr
//   mmu_req_*/mmu_resp_*         translation request / 1-cycle response pulse
//   imem_req_*                   memory read request (valid/ready handshake)
//   imem_rvalid_i/rdata_i/rerr_i read response pulse, data, bus error
//   out_valid_o/ready_i          queue head handshake toward IF/ID
//   out_pc_o/inst_o/trap_o       head entry; trap = {page, access, misaligned}
//   busy_o                       a fetch is in flight
module ifu_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            mmu_enable_i,
  output logic            mmu_req_valid_o,
  output logic [XLEN-1:0] mmu_req_vaddr_o,
  input  logic            mmu_resp_valid_i,
  input  logic [XLEN-1:0] mmu_resp_paddr_i,
  input  logic            mmu_page_fault_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_rerr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_inst_o,
  output logic [2:0]      out_trap_o,
  output logic            busy_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_XLATE, S_REQ, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;        // next pc to fetch
  logic [XLEN-1:0] fetch_pc_q;  // pc of the fetch in flight; immune to redirects
  logic [XLEN-1:0] paddr_q;
  logic            kill_q, halt_q;

  logic [XLEN-1:0] q_pc   [QDEPTH];
  logic [31:0]     q_inst [QDEPTH];
  logic [2:0]      q_trap [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            issue, misaligned, discard, pop;
  logic            push, set_halt, adv_pc;
  logic [XLEN-1:0] push_pc;
  logic [31:0]     push_inst;
  logic [2:0]      push_trap;

  // Only one fetch is ever in flight, so one free slot at issue time is
  // enough to guarantee the eventual push fits.
  assign issue      = (state_q == S_IDLE) && !halt_q && !redirect_valid_i &&
                      (count_q < CW'(QDEPTH));
  assign misaligned = (pc_q[1:0] != 2'b00);
  // A redirect on the response cycle kills that response just like kill_q.
  assign discard    = kill_q || redirect_valid_i;
  assign pop        = out_ready_i && (count_q != '0);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_pc   = fetch_pc_q;
    push_inst = '0;
    push_trap = '0;
    set_halt  = 1'b0;
    adv_pc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          if (misaligned) begin
            push      = 1'b1;
            push_pc   = pc_q;
            push_trap = 3'b001;
            set_halt  = 1'b1;
          end else begin
            state_d = mmu_enable_i ? S_XLATE : S_REQ;
          end
        end
      end
      S_XLATE: begin
        if (mmu_resp_valid_i) begin
          if (mmu_page_fault_i) begin
            state_d = S_IDLE;
            if (!discard) begin
              push      = 1'b1;
              push_trap = 3'b100;
              set_halt  = 1'b1;
            end
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (imem_req_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (imem_rvalid_i) begin
          state_d = S_IDLE;
          if (!discard) begin
            push = 1'b1;
            if (imem_rerr_i) begin
              push_trap = 3'b010;
              set_halt  = 1'b1;
            end else begin
              push_inst = imem_rdata_i;
              adv_pc    = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      paddr_q    <= '0;
      kill_q     <= 1'b0;
      halt_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;

      if (issue && !misaligned) begin
        fetch_pc_q <= pc_q;
        paddr_q    <= pc_q;
      end else if ((state_q == S_XLATE) && mmu_resp_valid_i && !mmu_page_fault_i) begin
        paddr_q <= mmu_resp_paddr_i;
      end

      // Returning to IDLE ends any killed transaction, even if a redirect
      // lands on that same cycle (its response is already being dropped).
      if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
        kill_q <= 1'b0;
      end else if (redirect_valid_i && (state_q != S_IDLE)) begin
        kill_q <= 1'b1;
      end

      if (redirect_valid_i) begin
        pc_q     <= redirect_pc_i;
        halt_q   <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (adv_pc)   pc_q   <= fetch_pc_q + XLEN'(4);
        if (set_halt) halt_q <= 1'b1;
        if (push)     wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)      rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !redirect_valid_i) begin
      q_pc[wr_ptr_q]   <= push_pc;
      q_inst[wr_ptr_q] <= push_inst;
      q_trap[wr_ptr_q] <= push_trap;
    end
  end

  assign mmu_req_valid_o  = (state_q == S_XLATE);
  assign mmu_req_vaddr_o  = fetch_pc_q;
  assign imem_req_valid_o = (state_q == S_REQ);
  assign imem_req_addr_o  = paddr_q;
  assign busy_o           = (state_q != S_IDLE);
  assign out_valid_o      = (count_q != '0);
  assign out_pc_o         = out_valid_o ? q_pc[rd_ptr_q]   : '0;
  assign out_inst_o       = out_valid_o ? q_inst[rd_ptr_q] : '0;
  assign out_trap_o       = out_valid_o ? q_trap[rd_ptr_q] : '0;

endmodule
